// File: rtl/csa_pkg.sv
// Shared helpers for the pipelined carry-save reduction tree: operand-count
// range check, per-level row counts, level count and result width.
package csa_pkg;

    localparam int CSA_NOPS_MIN = 3;
    localparam int CSA_NOPS_MAX = 9;

    // True when the operand count is one the tree is built for.
    function automatic bit csa_nops_ok(input int nops);
        return (nops >= CSA_NOPS_MIN) && (nops <= CSA_NOPS_MAX);
    endfunction

    // Rows present at the input of level lvl (lvl = 0 is the operand set).
    // Each level turns every full group of 3 rows into 2 and passes leftovers.
    function automatic int csa_rows(input int nops, input int lvl);
        int r;
        r = nops;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to reach a single carry-save pair.
    function automatic int csa_levels(input int nops);
        int r;
        int l;
        r = nops;
        l = 0;
        for (int i = 0; (i < 16) && (r > 2); i++) begin
            r = 2 * (r / 3) + (r % 3);
            l = l + 1;
        end
        return l;
    endfunction

    // Result width: enough headroom for the sum of nops operands.
    function automatic int csa_ow(input int w, input int nops);
        return w + $clog2(nops);
    endfunction

endpackage

// File: rtl/csa_tree_pipe_row.sv
// One combinational row of 3:2 compressors. s is the bitwise sum, t is the
// majority (carry) word already shifted left by one with bit 0 cleared and
// the carry out of the top bit dropped (results wrap mod 2^OW).
module csa32_row #(
    parameter int OW = 8
) (
    input  logic [OW-1:0] x,
    input  logic [OW-1:0] y,
    input  logic [OW-1:0] z,
    output logic [OW-1:0] t,
    output logic [OW-1:0] s
);

    assign s = x ^ y ^ z;

    assign t = {(x[OW-2:0] & y[OW-2:0]) |
                (x[OW-2:0] & z[OW-2:0]) |
                (y[OW-2:0] & z[OW-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand carry-save reduction tree with a final
// carry-propagate add. One register stage per compressor level plus one for
// the resolved result; a single global enable stalls the whole pipe.
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter  int W      = 13,
    parameter  int NOPS   = 4,
    parameter  int SIGNED = 0,
    parameter  int TAG_W  = 4,
    localparam int OW     = csa_ow(W, NOPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NOPS*W-1:0]   in_ops,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out_t,
    output logic [OW-1:0]       out_s,
    output logic [OW-1:0]       out_sum,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int L = csa_levels(NOPS);

    if (!csa_nops_ok(NOPS)) begin : gen_bad_nops
        $error("csa_tree_pipe: NOPS=%0d is outside the supported range 3..9", NOPS);
    end

    // Whole pipe advances together; it only stops when a result is waiting
    // at the output and the consumer is not taking it. Bubbles are kept.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // valid_reg[gi] belongs to level gi; valid_reg[L] is the output stage.
    logic [L:0]            valid_reg;
    logic [L:0][TAG_W-1:0] tag_reg;

    // Operands widened to the result width before the first level.
    logic [NOPS-1:0][OW-1:0] ext_rows;

    for (genvar gi = 0; gi < NOPS; gi++) begin : gen_ext
        if (SIGNED != 0) begin : gen_sext
            assign ext_rows[gi] = {{(OW-W){in_ops[gi*W+W-1]}}, in_ops[gi*W +: W]};
        end else begin : gen_zext
            assign ext_rows[gi] = {{(OW-W){1'b0}}, in_ops[gi*W +: W]};
        end
    end

    // Compressor levels: each sized for exactly the rows it sees.
    for (genvar gi = 0; gi < L; gi++) begin : gen_lvl
        localparam int N_IN   = csa_rows(NOPS, gi);
        localparam int N_GRP  = N_IN / 3;
        localparam int N_LEFT = N_IN % 3;
        localparam int N_OUT  = 2 * N_GRP + N_LEFT;

        logic [N_IN-1:0][OW-1:0]  rows_in;
        logic [N_OUT-1:0][OW-1:0] rows_next;
        logic [N_OUT-1:0][OW-1:0] rows_reg;

        if (gi == 0) begin : gen_src_ops
            assign rows_in = ext_rows;
        end else begin : gen_src_prev
            assign rows_in = gen_lvl[gi-1].rows_reg;
        end

        // Full groups of three become a (carry, sum) pair, carry first.
        for (genvar gj = 0; gj < N_GRP; gj++) begin : gen_grp
            csa32_row #(
                .OW (OW)
            ) u_row (
                .x (rows_in[3*gj]),
                .y (rows_in[3*gj+1]),
                .z (rows_in[3*gj+2]),
                .t (rows_next[2*gj]),
                .s (rows_next[2*gj+1])
            );
        end

        // Leftover rows ride along untouched behind the compressed pairs.
        for (genvar gj = 0; gj < N_LEFT; gj++) begin : gen_pass
            assign rows_next[2*N_GRP+gj] = rows_in[3*N_GRP+gj];
        end

        // Level register, frozen while the pipe is stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rows_reg <= '0;
            end else if (en) begin
                rows_reg <= rows_next;
            end
        end
    end

    // The last level always reduces three rows, so row 0 is the carry word
    // and row 1 the sum word of the final pair.
    logic [1:0][OW-1:0] last_rows;
    logic [OW-1:0]      fin_sum;

    assign last_rows = gen_lvl[L-1].rows_reg;
    assign fin_sum   = last_rows[0] + last_rows[1];

    logic [OW-1:0] out_t_reg;
    logic [OW-1:0] out_s_reg;
    logic [OW-1:0] out_sum_reg;

    // Valid bits and tags shift in lockstep with the level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            tag_reg   <= '0;
        end else if (en) begin
            valid_reg <= {valid_reg[L-1:0], in_valid};
            tag_reg   <= {tag_reg[L-1:0], in_tag};
        end
    end

    // Output stage: resolved sum registered together with its carry-save pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_t_reg   <= '0;
            out_s_reg   <= '0;
            out_sum_reg <= '0;
        end else if (en) begin
            out_t_reg   <= last_rows[0];
            out_s_reg   <= last_rows[1];
            out_sum_reg <= fin_sum;
        end
    end

    assign out_valid = valid_reg[L];
    assign out_tag   = tag_reg[L];
    assign out_t     = out_t_reg;
    assign out_s     = out_s_reg;
    assign out_sum   = out_sum_reg;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: three instances (unsigned 4x8, signed 4x8,
// unsigned 9x13) share handshake controls; an arithmetic scoreboard checks
// every result, plus directed vectors, back-to-back, stall and reset cases.
module tb_csa_tree_pipe;

    localparam int OWA = 10;
    localparam int OWC = 17;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   in_tag = '0;
    logic [31:0]  ops_a = '0;
    logic [116:0] ops_c = '0;

    logic           in_ready_a, out_valid_a;
    logic [OWA-1:0] t_a, s_a, sum_a;
    logic [3:0]     tag_a;
    logic           in_ready_b, out_valid_b;
    logic [OWA-1:0] t_b, s_b, sum_b;
    logic [3:0]     tag_b;
    logic           in_ready_c, out_valid_c;
    logic [OWC-1:0] t_c, s_c, sum_c;
    logic [3:0]     tag_c;

    csa_tree_pipe #(.W(8), .NOPS(4), .SIGNED(0), .TAG_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ops(ops_a), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_t(t_a), .out_s(s_a), .out_sum(sum_a), .out_tag(tag_a));

    csa_tree_pipe #(.W(8), .NOPS(4), .SIGNED(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ops(ops_a), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_t(t_b), .out_s(s_b), .out_sum(sum_b), .out_tag(tag_b));

    csa_tree_pipe #(.W(13), .NOPS(9), .SIGNED(0), .TAG_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_ops(ops_c), .in_tag(in_tag), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_t(t_c), .out_s(s_c), .out_sum(sum_c), .out_tag(tag_c));

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain sum of the n operands, each read as signed or
    // unsigned w-bit integers, reduced mod 2^ow.
    function automatic longint ref_sum(input logic [127:0] v, input int w, input int n,
                                       input bit sg, input int ow);
        longint acc;
        longint e;
        logic [127:0] sh;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            sh = v >> (i * w);
            e  = longint'(sh[63:0]) & ((longint'(1) << w) - 1);
            if (sg && e[w-1]) e = e - (longint'(1) << w);
            acc = acc + e;
        end
        return acc & ((longint'(1) << ow) - 1);
    endfunction

    // Scoreboard: per-instance FIFO of {tag, sum} expected results.
    longint sb [3][64];
    int     wr [3];
    int     rd [3];
    bit     hold_prev [3];
    longint saved [3][4];

    bit     log_en = 1'b0;
    int     log_n = 0;
    longint log_sum [16];
    longint log_tag [16];
    int     log_cyc [16];

    task automatic mon(input int id, input logic rdy, input logic vld,
                       input longint t, input longint s, input longint sum,
                       input longint tg, input longint exp, input int ow);
        string  nm;
        longint e;
        nm = $sformatf("dut%0d", id);
        if (hold_prev[id]) begin
            chk({nm, "_hold_valid"}, longint'(vld), 1);
            chk({nm, "_hold_t"}, t, saved[id][0]);
            chk({nm, "_hold_s"}, s, saved[id][1]);
            chk({nm, "_hold_sum"}, sum, saved[id][2]);
            chk({nm, "_hold_tag"}, tg, saved[id][3]);
        end
        if (in_valid && rdy) begin
            sb[id][wr[id] % 64] = (longint'(in_tag) << 32) | exp;
            wr[id] = wr[id] + 1;
        end
        if (vld && out_ready) begin
            if (rd[id] == wr[id]) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s_spurious: got out_valid=1 expected out_valid=0 (sum=0x%0h)", nm, sum);
            end else begin
                e = sb[id][rd[id] % 64];
                rd[id] = rd[id] + 1;
                chk({nm, "_sum"}, sum, e & 64'hFFFF_FFFF);
                chk({nm, "_tag"}, tg, e >>> 32);
                chk({nm, "_ts"}, (t + s) & ((longint'(1) << ow) - 1), sum);
            end
        end
        hold_prev[id] = vld && !out_ready;
        saved[id][0] = t;
        saved[id][1] = s;
        saved[id][2] = sum;
        saved[id][3] = tg;
    endtask

    // Monitor at the falling edge: inputs and outputs are stable there and
    // describe the handshakes of the upcoming rising edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr[i] = 0;
                rd[i] = 0;
                hold_prev[i] = 1'b0;
            end
        end else begin
            mon(0, in_ready_a, out_valid_a, t_a, s_a, sum_a, tag_a,
                ref_sum({96'd0, ops_a}, 8, 4, 1'b0, OWA), OWA);
            mon(1, in_ready_b, out_valid_b, t_b, s_b, sum_b, tag_b,
                ref_sum({96'd0, ops_a}, 8, 4, 1'b1, OWA), OWA);
            mon(2, in_ready_c, out_valid_c, t_c, s_c, sum_c, tag_c,
                ref_sum({11'd0, ops_c}, 13, 9, 1'b0, OWC), OWC);
            if (out_valid_a && out_ready) begin
                $display("xfer dut_a cyc=%0d sum=0x%0h t=0x%0h s=0x%0h tag=0x%0h",
                         cyc, sum_a, t_a, s_a, tag_a);
                if (log_en && log_n < 16) begin
                    log_sum[log_n] = sum_a;
                    log_tag[log_n] = tag_a;
                    log_cyc[log_n] = cyc;
                    log_n = log_n + 1;
                end
            end
        end
    end

    typedef struct {
        logic [31:0]  ops8;
        logic [116:0] ops13;
        logic [3:0]   tag;
        logic [9:0]   exp_a;
        logic [9:0]   exp_b;
        logic [16:0]  exp_c;
    } vec_t;

    vec_t vecs [4];

    // Apply one operand set on an idle pipe, measure latency on each
    // instance and compare the captured result with the table.
    task automatic apply_vec(input int idx, input vec_t v);
        int lat_a, lat_b, lat_c;
        longint got_a, got_b, got_c, got_tag;
        lat_a = -1; lat_b = -1; lat_c = -1;
        got_a = 0; got_b = 0; got_c = 0; got_tag = 0;
        ops_a = v.ops8;
        ops_c = v.ops13;
        in_tag = v.tag;
        in_valid = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid_a && lat_a < 0) begin lat_a = n; got_a = sum_a; got_tag = tag_a; end
            if (out_valid_b && lat_b < 0) begin lat_b = n; got_b = sum_b; end
            if (out_valid_c && lat_c < 0) begin lat_c = n; got_c = sum_c; end
        end
        chk($sformatf("vec%0d_lat_a", idx), lat_a, 3);
        chk($sformatf("vec%0d_lat_b", idx), lat_b, 3);
        chk($sformatf("vec%0d_lat_c", idx), lat_c, 5);
        chk($sformatf("vec%0d_sum_a", idx), got_a, v.exp_a);
        chk($sformatf("vec%0d_sum_b", idx), got_b, v.exp_b);
        chk($sformatf("vec%0d_sum_c", idx), got_c, v.exp_c);
        chk($sformatf("vec%0d_tag_a", idx), got_tag, v.tag);
    endtask

    initial begin
        logic [116:0] tmp13;
        logic [127:0] r128;
        int cnt;

        // Directed table.
        vecs[0].ops8 = 32'hFFFF_FFFF; vecs[0].ops13 = '1; vecs[0].tag = 4'h5;
        vecs[0].exp_a = 10'h3FC; vecs[0].exp_b = 10'h3FC; vecs[0].exp_c = 17'h11FF7;

        vecs[1].ops8 = 32'h0000_0180; vecs[1].ops13 = '0; vecs[1].tag = 4'hA;
        vecs[1].exp_a = 10'h081; vecs[1].exp_b = 10'h381; vecs[1].exp_c = 17'h0;

        tmp13 = '0;
        for (int i = 0; i < 9; i++) tmp13[i*13 +: 13] = 13'(i + 1);
        vecs[2].ops8 = 32'h7F7F_7F7F; vecs[2].ops13 = tmp13; vecs[2].tag = 4'h3;
        vecs[2].exp_a = 10'h1FC; vecs[2].exp_b = 10'h1FC; vecs[2].exp_c = 17'h2D;

        tmp13 = '0;
        tmp13[12:0] = 13'h1FFF;
        tmp13[8*13 +: 13] = 13'h1000;
        vecs[3].ops8 = 32'h0000_00FF; vecs[3].ops13 = tmp13; vecs[3].tag = 4'hC;
        vecs[3].exp_a = 10'h0FF; vecs[3].exp_b = 10'h3FF; vecs[3].exp_c = 17'h2FFF;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_a", out_valid_a, 0);
        chk("rst_out_valid_c", out_valid_c, 0);
        chk("rst_sum_a", sum_a, 0);
        chk("rst_t_a", t_a, 0);
        chk("rst_s_c", s_c, 0);
        chk("rst_tag_b", tag_b, 0);
        chk("rst_in_ready_a", in_ready_a, 1);

        // Release and offer the first set immediately: it must be taken on
        // the first edge after deassertion.
        rst_n = 1'b1;
        for (int v = 0; v < 4; v++) apply_vec(v, vecs[v]);

        // Back-to-back {k,k,k,k}, k = 1..8.
        log_n = 0;
        log_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            ops_a = {4{8'(k)}};
            in_tag = 4'(k);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        log_en = 1'b0;
        chk("b2b_count", log_n, 8);
        for (int i = 0; i < 8 && i < log_n; i++) begin
            chk($sformatf("b2b_sum%0d", i), log_sum[i], 4 * (i + 1));
            chk($sformatf("b2b_tag%0d", i), log_tag[i], i + 1);
            if (i > 0) chk($sformatf("b2b_gap%0d", i), log_cyc[i] - log_cyc[i-1], 1);
        end

        // Backpressure: consumer stalls while sets keep arriving.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ops_a = $urandom;
            r128 = {$urandom, $urandom, $urandom, $urandom};
            ops_c = r128[116:0];
            in_tag = 4'($urandom);
            @(posedge clk);
            #1;
        end
        chk("bp_in_ready_a", in_ready_a, 0);
        chk("bp_in_ready_c", in_ready_c, 0);
        chk("bp_out_valid_a", out_valid_a, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("bp_drain%0d", i), wr[i] - rd[i], 0);

        // Reset while operations are in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ops_a = $urandom;
            in_tag = 4'($urandom);
            @(posedge clk);
            #1;
        end
        chk("mid_pre_valid_a", out_valid_a, 1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_valid_a", out_valid_a, 0);
        chk("mid_valid_b", out_valid_b, 0);
        chk("mid_valid_c", out_valid_c, 0);
        chk("mid_sum_a", sum_a, 0);
        chk("mid_t_a", t_a, 0);
        chk("mid_s_b", s_b, 0);
        chk("mid_tag_a", tag_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b || out_valid_c) cnt = cnt + 1;
        end
        chk("mid_no_stale", cnt, 0);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            ops_a = $urandom;
            r128 = {$urandom, $urandom, $urandom, $urandom};
            ops_c = r128[116:0];
            in_tag = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rnd_drain%0d", i), wr[i] - rd[i], 0);
        chk("rnd_traffic_seen", (wr[0] > 100) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
